// File: rtl/rc_nrzi_unstuff.sv
// USB receive front end: NRZI decode, bit unstuffing, LSB-first deserializer.
// Reports per-packet stuffing, alignment and overflow status at end-of-packet.
module rc_nrzi_unstuff #(
    parameter int MAX_BYTES = 11,
    parameter int CW        = $clog2(MAX_BYTES + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          line_bit,
    input  logic          eop,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    output logic [CW-1:0] byte_cnt,
    output logic          pkt_done,
    output logic          stuff_err,
    output logic          align_err,
    output logic          ovf_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          prev_lvl_q, prev_lvl_d;
    logic [2:0]    ones_q, ones_d;
    logic [2:0]    bitpos_q, bitpos_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    byte_out_q, byte_out_d;
    logic          byte_valid_q, byte_valid_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          pkt_done_q, pkt_done_d;
    logic          stuff_err_q, stuff_err_d;
    logic          align_err_q, align_err_d;
    logic          ovf_err_q, ovf_err_d;

    logic          d_bit;
    logic [7:0]    next_byte;

    assign d_bit     = (line_bit == prev_lvl_q);
    assign next_byte = {d_bit, sr_q[7:1]};

    // Next-state: start rearms; otherwise a bit is handled before a same-cycle eop.
    always_comb begin
        state_d      = state_q;
        prev_lvl_d   = prev_lvl_q;
        ones_d       = ones_q;
        bitpos_d     = bitpos_q;
        sr_d         = sr_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        byte_cnt_d   = byte_cnt_q;
        pkt_done_d   = 1'b0;
        stuff_err_d  = stuff_err_q;
        align_err_d  = align_err_q;
        ovf_err_d    = ovf_err_q;

        if (start) begin
            state_d     = RUN;
            prev_lvl_d  = 1'b0;
            ones_d      = 3'd0;
            bitpos_d    = 3'd0;
            byte_cnt_d  = '0;
            stuff_err_d = 1'b0;
            align_err_d = 1'b0;
            ovf_err_d   = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bit_valid) begin
                        prev_lvl_d = line_bit;
                        if (ones_q == 3'd6) begin
                            if (!d_bit) begin
                                ones_d = 3'd0;
                            end else begin
                                stuff_err_d = 1'b1;
                                state_d     = DISCARD;
                            end
                        end else begin
                            ones_d = d_bit ? ones_q + 3'd1 : 3'd0;
                            sr_d   = next_byte;
                            if (bitpos_q == 3'd7) begin
                                bitpos_d = 3'd0;
                                if (byte_cnt_q == CW'(MAX_BYTES)) begin
                                    ovf_err_d = 1'b1;
                                    state_d   = DISCARD;
                                end else begin
                                    byte_out_d   = next_byte;
                                    byte_valid_d = 1'b1;
                                    byte_cnt_d   = byte_cnt_q + CW'(1);
                                end
                            end else begin
                                bitpos_d = bitpos_q + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase

            if (eop && state_q != IDLE) begin
                if (state_d == RUN && bitpos_d != 3'd0) begin
                    align_err_d = 1'b1;
                end
                pkt_done_d = 1'b1;
                state_d    = IDLE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prev_lvl_q   <= 1'b0;
            ones_q       <= 3'd0;
            bitpos_q     <= 3'd0;
            sr_q         <= 8'h00;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_cnt_q   <= '0;
            pkt_done_q   <= 1'b0;
            stuff_err_q  <= 1'b0;
            align_err_q  <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_lvl_q   <= prev_lvl_d;
            ones_q       <= ones_d;
            bitpos_q     <= bitpos_d;
            sr_q         <= sr_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_cnt_q   <= byte_cnt_d;
            pkt_done_q   <= pkt_done_d;
            stuff_err_q  <= stuff_err_d;
            align_err_q  <= align_err_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_cnt   = byte_cnt_q;
    assign pkt_done   = pkt_done_q;
    assign stuff_err  = stuff_err_q;
    assign align_err  = align_err_q;
    assign ovf_err    = ovf_err_q;

endmodule
